// File: rtl/popcount_stream.sv
// Pipelined streaming popcount with per-word and framed-accumulate modes.
// Three register stages (chunk partials, word sum, output/accumulator).
module popcount_stream #(
  parameter int BITS     = 16,
  parameter int CHUNK    = 4,
  parameter int ACC_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS-1:0]     in_data,
  input  logic                in_last,
  input  logic                in_mode,
  input  logic [ACC_BITS-1:0] threshold,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_BITS-1:0] out_count,
  output logic                out_ovf,
  output logic                out_ge
);

  localparam int NCH = BITS / CHUNK;
  localparam int PW  = $clog2(CHUNK) + 1;

  logic en;

  logic                   s1_valid_q;
  logic                   s1_mode_q;
  logic                   s1_last_q;
  logic [NCH-1:0][PW-1:0] s1_part_q;
  logic [NCH-1:0][PW-1:0] s1_part_d;

  logic                s2_valid_q;
  logic                s2_mode_q;
  logic                s2_last_q;
  logic [ACC_BITS-1:0] s2_cnt_q;
  logic [ACC_BITS-1:0] s2_cnt_d;

  logic                out_valid_q, out_valid_d;
  logic [ACC_BITS-1:0] out_count_q, out_count_d;
  logic                out_ovf_q, out_ovf_d;
  logic                out_ge_q, out_ge_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic                acc_ovf_q, acc_ovf_d;

  logic [ACC_BITS:0]   acc_sum;
  logic                sat;
  logic [ACC_BITS-1:0] sat_sum;

  // Whole pipeline moves in lockstep, frozen only by a stalled output.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en && rst_n;

  always_comb begin
    s1_part_d = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int b = 0; b < CHUNK; b++) begin
        s1_part_d[c] = s1_part_d[c] + PW'(in_data[c*CHUNK+b]);
      end
    end
  end

  always_comb begin
    s2_cnt_d = '0;
    for (int c = 0; c < NCH; c++) begin
      s2_cnt_d = s2_cnt_d + ACC_BITS'(s1_part_q[c]);
    end
  end

  assign acc_sum = {1'b0, acc_q} + {1'b0, s2_cnt_q};
  assign sat     = acc_sum[ACC_BITS];
  assign sat_sum = sat ? '1 : acc_sum[ACC_BITS-1:0];

  always_comb begin
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_ge_d    = out_ge_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    if (en) begin
      out_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (!s2_mode_q) begin
          out_valid_d = 1'b1;
          out_count_d = s2_cnt_q;
          out_ovf_d   = 1'b0;
          out_ge_d    = (s2_cnt_q >= threshold);
        end else if (s2_last_q) begin
          out_valid_d = 1'b1;
          out_count_d = sat_sum;
          out_ovf_d   = acc_ovf_q | sat;
          out_ge_d    = (sat_sum >= threshold);
          acc_d       = '0;
          acc_ovf_d   = 1'b0;
        end else begin
          acc_d       = sat_sum;
          acc_ovf_d   = acc_ovf_q | sat;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_part_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_ge_q    <= 1'b0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      if (en) begin
        s1_valid_q <= in_valid;
        s1_mode_q  <= in_mode;
        s1_last_q  <= in_last;
        s1_part_q  <= s1_part_d;
        s2_valid_q <= s1_valid_q;
        s2_mode_q  <= s1_mode_q;
        s2_last_q  <= s1_last_q;
        s2_cnt_q   <= s2_cnt_d;
      end
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_ge_q    <= out_ge_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_ge    = out_ge_q;

endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream: directed scenarios plus randomized traffic
// against a frame-level reference model, on 16-bit and 5-bit accumulators.
module tb_popcount_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_last, in_mode, out_ready;
  logic [15:0] in_data, threshold;
  logic        in_ready, o_valid, o_ovf, o_ge;
  logic [15:0] o_count;
  logic        in_ready5, o_valid5, o_ovf5, o_ge5;
  logic [4:0]  o_count5;

  popcount_stream #(.BITS(16), .CHUNK(4), .ACC_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_mode(in_mode),
    .threshold(threshold), .out_valid(o_valid), .out_ready(out_ready),
    .out_count(o_count), .out_ovf(o_ovf), .out_ge(o_ge)
  );

  popcount_stream #(.BITS(16), .CHUNK(4), .ACC_BITS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
    .in_data(in_data), .in_last(in_last), .in_mode(in_mode),
    .threshold(threshold[4:0]), .out_valid(o_valid5), .out_ready(out_ready),
    .out_count(o_count5), .out_ovf(o_ovf5), .out_ge(o_ge5)
  );

  typedef struct {
    int cnt;
    bit ovf;
    bit ge;
    int cyc;
  } res_t;

  res_t exp16[$], exp5[$], got16[$], got5[$];
  int   acc_cyc[$];
  int   nvec = 0, nerr = 0, cyc = 0;
  int   rdy_bad = 0, hold_bad = 0, stall_seen = 0, tmo = 0;
  int   acc16 = 0, acc5 = 0;
  bit   sov16 = 0, sov5 = 0;
  bit   stall_prev = 0, accepted = 0;
  logic [15:0] cnt_prev;

  // Frame-level reference: returns 1 when the beat yields a result.
  function automatic bit model(input int cnt, input bit mode, input bit last,
                               input int maxv, input int thr,
                               inout int acc, inout bit sov,
                               output res_t r);
    int s;
    bit st;
    r.cyc = 0;
    if (!mode) begin
      r.cnt = cnt; r.ovf = 0; r.ge = (cnt >= thr);
      return 1'b1;
    end
    s  = acc + cnt;
    st = (s > maxv);
    if (st) s = maxv;
    if (last) begin
      r.cnt = s; r.ovf = sov | st; r.ge = (s >= thr);
      acc = 0; sov = 0;
      return 1'b1;
    end
    acc = s; sov = sov | st;
    r.cnt = 0; r.ovf = 0; r.ge = 0;
    return 1'b0;
  endfunction

  task automatic step();
    res_t r;
    bit   er;
    @(negedge clk);
    cyc++;
    accepted = 0;
    if (rst_n) begin
      er = !(o_valid && !out_ready);
      if (in_ready !== er || in_ready5 !== in_ready) rdy_bad++;
      if (stall_prev && o_count !== cnt_prev) hold_bad++;
      if (o_valid && !out_ready) stall_seen++;
      if (in_valid && in_ready) begin
        accepted = 1;
        acc_cyc.push_back(cyc);
        if (model($countones(in_data), in_mode, in_last, 65535,
                  int'(threshold), acc16, sov16, r))
          exp16.push_back(r);
        if (model($countones(in_data), in_mode, in_last, 31,
                  int'(threshold) & 31, acc5, sov5, r))
          exp5.push_back(r);
      end
      if (o_valid && out_ready) begin
        r.cnt = int'(o_count); r.ovf = o_ovf; r.ge = o_ge; r.cyc = cyc;
        got16.push_back(r);
      end
      if (o_valid5 && out_ready) begin
        r.cnt = int'(o_count5); r.ovf = o_ovf5; r.ge = o_ge5; r.cyc = cyc;
        got5.push_back(r);
      end
    end else begin
      acc16 = 0; sov16 = 0; acc5 = 0; sov5 = 0;
    end
    stall_prev = rst_n && o_valid && !out_ready;
    cnt_prev   = o_count;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp16.delete(); exp5.delete(); got16.delete(); got5.delete();
    acc_cyc.delete();
  endtask

  task automatic send(input logic [15:0] d, input bit mode, input bit last);
    in_data = d; in_mode = mode; in_last = last; in_valid = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (accepted) break;
      if (i == 49) tmo++;
    end
  endtask

  task automatic drain(input int n, output bit ok);
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < 60; i++) begin
      if (got16.size() >= n) break;
      step();
    end
    for (int i = 0; i < 4; i++) step();
    ok = (got16.size() >= n) && (tmo == 0);
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; in_data = 16'hFFFF; in_mode = 0; in_last = 0;
    out_ready = 1; threshold = 0;
    step(); step();
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    in_valid = 0;
    rst_n = 1;
    step();
    nvec++;
    if (o_valid !== 1'b0 || o_count !== 16'd0 || o_ovf !== 1'b0 ||
        o_ge !== 1'b0 || o_valid5 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_outputs: got v=%b c=%0d o=%b g=%b expected zeros",
               o_valid, o_count, o_ovf, o_ge);
    end
  endtask

  task automatic test_word();
    int ec[4] = '{0, 16, 2, 8};
    bit eg[4] = '{0, 1, 0, 1};
    bit ok;
    clear_q();
    threshold = 8; out_ready = 1;
    send(16'h0000, 0, 0);
    send(16'hFFFF, 0, 0);
    send(16'h8001, 0, 0);
    send(16'hAAAA, 0, 0);
    drain(4, ok);
    nvec++;
    if (!ok || got16.size() != 4) begin
      nerr++; $display("FAIL word_n: got %0d results expected 4", got16.size());
    end
    for (int i = 0; i < 4 && i < got16.size(); i++) begin
      nvec++;
      if (got16[i].cnt !== ec[i] || got16[i].ge !== eg[i] ||
          got16[i].ovf !== 1'b0) begin
        nerr++;
        $display("FAIL word_res[%0d]: got c=%0d ge=%b ovf=%b expected c=%0d ge=%b ovf=0",
                 i, got16[i].cnt, got16[i].ge, got16[i].ovf, ec[i], eg[i]);
      end
      nvec++;
      if (got16[i].cyc !== acc_cyc[0] + 3 + i) begin
        nerr++;
        $display("FAIL word_timing[%0d]: got cycle %0d expected %0d",
                 i, got16[i].cyc, acc_cyc[0] + 3 + i);
      end
    end
  endtask

  task automatic test_accum();
    bit ok;
    clear_q();
    threshold = 30;
    send(16'h000F, 1, 0);
    send(16'h00FF, 1, 0);
    send(16'hFFFF, 1, 1);
    drain(1, ok);
    nvec++;
    if (!ok || got16.size() != 1) begin
      nerr++; $display("FAIL accum_n: got %0d results expected 1", got16.size());
    end else begin
      nvec++;
      if (got16[0].cnt !== 28 || got16[0].ovf !== 1'b0 || got16[0].ge !== 1'b0) begin
        nerr++;
        $display("FAIL accum_res: got c=%0d ovf=%b ge=%b expected c=28 ovf=0 ge=0",
                 got16[0].cnt, got16[0].ovf, got16[0].ge);
      end
      nvec++;
      if (got16[0].cyc !== acc_cyc[2] + 3) begin
        nerr++;
        $display("FAIL accum_timing: got cycle %0d expected %0d",
                 got16[0].cyc, acc_cyc[2] + 3);
      end
    end
  endtask

  task automatic test_saturate();
    bit ok;
    clear_q();
    threshold = 20;
    send(16'hFFFF, 1, 0);
    send(16'hFFFF, 1, 1);
    send(16'h0003, 1, 1);
    drain(2, ok);
    nvec++;
    if (!ok || got5.size() != 2 || got16.size() != 2) begin
      nerr++;
      $display("FAIL sat_n: got %0d/%0d results expected 2", got5.size(), got16.size());
    end else begin
      nvec++;
      if (got5[0].cnt !== 31 || got5[0].ovf !== 1'b1 || got5[0].ge !== 1'b1) begin
        nerr++;
        $display("FAIL sat_frame: got c=%0d ovf=%b ge=%b expected c=31 ovf=1 ge=1",
                 got5[0].cnt, got5[0].ovf, got5[0].ge);
      end
      nvec++;
      if (got5[1].cnt !== 2 || got5[1].ovf !== 1'b0) begin
        nerr++;
        $display("FAIL sat_next: got c=%0d ovf=%b expected c=2 ovf=0",
                 got5[1].cnt, got5[1].ovf);
      end
      nvec++;
      if (got16[0].cnt !== 32 || got16[0].ovf !== 1'b0) begin
        nerr++;
        $display("FAIL wide_frame: got c=%0d ovf=%b expected c=32 ovf=0",
                 got16[0].cnt, got16[0].ovf);
      end
    end
  endtask

  task automatic test_backpressure();
    int  sent = 0;
    int  rb0 = rdy_bad, hb0 = hold_bad, ss0 = stall_seen;
    clear_q();
    threshold = 9;
    in_mode = 0; in_last = 0;
    in_data = 16'($urandom);
    for (int t = 0; t < 200 && (sent < 6 || got16.size() < 6); t++) begin
      out_ready = !(t >= 4 && t < 8);
      in_valid  = (sent < 6) && (t < 3 || $urandom_range(0, 1) == 1);
      step();
      if (accepted) begin
        sent++;
        in_data = 16'($urandom);
      end
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) step();
    nvec++;
    if (got16.size() != 6 || exp16.size() != 6) begin
      nerr++;
      $display("FAIL bp_n: got %0d results expected 6", got16.size());
    end
    for (int i = 0; i < 6 && i < got16.size() && i < exp16.size(); i++) begin
      nvec++;
      if (got16[i].cnt !== exp16[i].cnt || got16[i].ge !== exp16[i].ge) begin
        nerr++;
        $display("FAIL bp_res[%0d]: got c=%0d ge=%b expected c=%0d ge=%b",
                 i, got16[i].cnt, got16[i].ge, exp16[i].cnt, exp16[i].ge);
      end
    end
    nvec++;
    if (rdy_bad !== rb0 || hold_bad !== hb0 || stall_seen == ss0) begin
      nerr++;
      $display("FAIL bp_stall: got ready_err=%0d hold_err=%0d stalls=%0d expected 0,0,>0",
               rdy_bad - rb0, hold_bad - hb0, stall_seen - ss0);
    end
  endtask

  task automatic test_interleave();
    bit ok;
    clear_q();
    threshold = 3;
    send(16'h0007, 1, 0);
    send(16'h0001, 0, 0);
    send(16'h0003, 1, 1);
    drain(2, ok);
    nvec++;
    if (!ok || got16.size() != 2) begin
      nerr++; $display("FAIL inter_n: got %0d results expected 2", got16.size());
    end else begin
      nvec++;
      if (got16[0].cnt !== 1 || got16[0].ge !== 1'b0 ||
          got16[1].cnt !== 5 || got16[1].ge !== 1'b1) begin
        nerr++;
        $display("FAIL inter_res: got %0d,%0d expected 1,5", got16[0].cnt, got16[1].cnt);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    clear_q();
    threshold = 0;
    send(16'h00FF, 1, 0);
    in_valid = 0;
    step(); step(); step();
    rst_n = 0;
    step();
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL midrst_ready: got %b expected 0", in_ready);
    end
    rst_n = 1;
    clear_q();
    send(16'h0001, 1, 1);
    drain(1, ok);
    nvec++;
    if (!ok || got16.size() != 1 || got16[0].cnt !== 1 || got16[0].ovf !== 1'b0) begin
      nerr++;
      $display("FAIL midrst_res: got n=%0d c=%0d expected n=1 c=1", got16.size(),
               got16.size() > 0 ? got16[0].cnt : -1);
    end
  endtask

  task automatic test_random();
    bit ok;
    int rb0 = rdy_bad, hb0 = hold_bad;
    clear_q();
    threshold = 16'($urandom_range(0, 40));
    for (int t = 0; t < 400; t++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 16'($urandom);
      in_mode   = 1'($urandom_range(0, 1));
      in_last   = ($urandom_range(0, 2) == 0);
      step();
    end
    out_ready = 1;
    send(16'h0000, 1, 1);
    drain(exp16.size(), ok);
    nvec++;
    if (!ok || got16.size() != exp16.size() || got5.size() != exp5.size()) begin
      nerr++;
      $display("FAIL rand_n: got %0d/%0d results expected %0d/%0d",
               got16.size(), got5.size(), exp16.size(), exp5.size());
    end
    for (int i = 0; i < got16.size() && i < exp16.size(); i++) begin
      nvec++;
      if (got16[i].cnt !== exp16[i].cnt || got16[i].ovf !== exp16[i].ovf ||
          got16[i].ge !== exp16[i].ge) begin
        nerr++;
        $display("FAIL rand16[%0d]: got c=%0d o=%b g=%b expected c=%0d o=%b g=%b",
                 i, got16[i].cnt, got16[i].ovf, got16[i].ge,
                 exp16[i].cnt, exp16[i].ovf, exp16[i].ge);
      end
    end
    for (int i = 0; i < got5.size() && i < exp5.size(); i++) begin
      nvec++;
      if (got5[i].cnt !== exp5[i].cnt || got5[i].ovf !== exp5[i].ovf ||
          got5[i].ge !== exp5[i].ge) begin
        nerr++;
        $display("FAIL rand5[%0d]: got c=%0d o=%b g=%b expected c=%0d o=%b g=%b",
                 i, got5[i].cnt, got5[i].ovf, got5[i].ge,
                 exp5[i].cnt, exp5[i].ovf, exp5[i].ge);
      end
    end
    nvec++;
    if (rdy_bad !== rb0 || hold_bad !== hb0) begin
      nerr++;
      $display("FAIL rand_hs: got ready_err=%0d hold_err=%0d expected 0,0",
               rdy_bad - rb0, hold_bad - hb0);
    end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_data = 0; in_mode = 0; in_last = 0;
    out_ready = 1; threshold = 0;
    test_reset();
    test_word();
    test_accum();
    test_saturate();
    test_backpressure();
    test_interleave();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/popcount_stream.md
Name: popcount_stream

Overview:
- Streaming, pipelined population counter. Counts the set bits in each BITS-wide input word.
- Two modes, selected per beat:
  - Word mode: emits one count per beat.
  - Accumulate mode: sums counts across a frame delimited by in_last and emits one total per frame.
- Valid/ready on both sides, with a threshold flag on every result.
- Sits between a switch/data source and a display or DMA sink; replaces the combinational bit counter where throughput and backpressure are needed.

Parameters:
- BITS, 16: input word width. Must be ≥2 and divisible by CHUNK.
- CHUNK, 4: bits per first-level partial count.
- ACC_BITS, 16: result/accumulator width. Must be ≥ $clog2(BITS)+1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  BITS  word to count.
- in_last  in  1  final beat of a frame (accumulate mode only).
- in_mode  in  1  0 = word mode, 1 = accumulate mode; sampled with each beat.
- threshold  in  ACC_BITS  compare value; sampled when a result is loaded into the output register.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_count  out  ACC_BITS  bit count (word) or frame total (accumulate).
- out_ovf  out  1  frame total saturated.
- out_ge  out  1  out_count ≥ threshold.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All stage valids, accumulator, out_valid, out_count, out_ovf and out_ge go to 0.
  - in_ready is 0 while rst_n=0.
  - Any in-flight beat or partial frame is discarded; no output from it ever appears.
- Pipeline: three register stages, each carrying valid, mode and last.
  - S1: CHUNK-wide partial popcounts, BITS/CHUNK of them, each $clog2(CHUNK)+1 bits.
  - S2: sum of the partials, zero-extended to ACC_BITS.
  - S3: output register (out_*).
- Advance enable: en = !out_valid || out_ready.
  - All stages shift only when en=1.
  - in_ready = en (when rst_n=1).
  - Input transfer occurs when in_valid && in_ready.
- Latency:
  - Word-mode beat accepted at edge N → out_valid=1 after edge N+3 when the sink never stalls.
  - Throughput is one beat per clock.
- Word mode (mode=0) beat at S3 load:
  - out_count = word count.
  - out_ovf = 0.
  - Accumulator untouched, so word-mode beats may interleave with an open accumulate frame.
- Accumulate mode (mode=1) beat at S3 load:
  - sum = acc + count, saturating at 2^ACC_BITS−1; a sticky ovf is set if saturation occurred.
  - If last=0: acc ← sum and no output is produced (out_valid does not rise for this beat).
  - If last=1:
    - out_count = sum, out_ovf = sticky ovf | saturation on this beat.
    - acc ← 0, sticky ovf ← 0.
    - A single-beat frame (last=1 on its first beat) is legal.
- out_ge = (loaded out_count ≥ threshold), computed from threshold at the S3-load edge.
- Output hold: out_* stay stable while out_valid && !out_ready. out_valid drops after a handshake unless a new result loads on the same edge.
- Simultaneous out handshake and new result: the new result loads on the same edge, out_valid stays 1 and there is no bubble.
- Backpressure: with out_ready=0 and out_valid=1, no stage may change and no beat may be lost or duplicated.

Test Plan:
- Reset, word mode, BITS=16, out_ready=1: send 0x0000, 0xFFFF, 0x8001, 0xAAAA back-to-back with threshold=8.
  - Required: out_count 0, 16, 2, 8 on consecutive cycles starting 3 cycles after the first accept.
  - out_ge 0, 1, 0, 1 respectively.
- Accumulate frame 0x000F, 0x00FF, 0xFFFF (last on third beat), threshold=30.
  - Required: a single output, out_count=28, out_ovf=0, out_ge=0; no out_valid for the first two beats.
- ACC_BITS=5, accumulate 0xFFFF, 0xFFFF (last).
  - Required: out_count=31 (saturated), out_ovf=1.
  - A following single-beat frame 0x0003 yields out_count=2, out_ovf=0.
- Backpressure: stream 6 word-mode beats with random in_valid and out_ready held low for 4 cycles mid-stream.
  - Required: all 6 counts delivered in order with no loss or duplication.
  - in_ready=0 exactly while out_valid && !out_ready.
  - out_count stable during the stall.
- Interleave: accumulate 0x0007 (last=0), word 0x0001, accumulate 0x0003 (last=1).
  - Required: outputs 1 (word), then 5 (frame).
- Reset mid-frame: accumulate 0x00FF (last=0), assert rst_n=0 for 1 cycle, then accumulate 0x0001 (last=1).
  - Required: out_count=1; nothing from before reset appears.
